crack_dispatch: RTL and testbench

CRACK_DISPATCH -- requirements
Module: crack_dispatch

---
 rtl/crack_dispatch.sv | 134 +++++++++++++
 tb/tb_crack_dispatch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crack_dispatch.sv
// Dispatches sequential candidate keys to LANES ARC4 crack lanes and collects results.
// Define CRACK_FOUND_ABORT_EN to finish on the first found key instead of draining busy lanes.
module crack_dispatch #(
  parameter int unsigned    LANES    = 2,
  parameter int unsigned    KEY_W    = 24,
  parameter logic [KEY_W:0] KEY_LAST = {1'b0, {KEY_W{1'b1}}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [LANES-1:0]       lane_rdy,
  output logic [LANES-1:0]       lane_en,
  output logic [LANES*KEY_W-1:0] lane_key,
  input  logic [LANES-1:0]       lane_found,
  output logic                   key_valid,
  output logic [KEY_W-1:0]       key,
  output logic [KEY_W:0]         keys_tried
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [KEY_W:0]   next_key;
  logic [LANES-1:0] busy, guard;
  logic [LANES-1:0] comp, found_vec, avail, sel;
  logic             found_any, dispatch, accept, picked;
  logic [KEY_W-1:0] min_key;
  logic [KEY_W:0]   comp_cnt;

  assign accept = rdy & en;

  // Completion, found-key minimum and lowest-index lane selection
  always_comb begin
    comp      = '0;
    found_vec = '0;
    sel       = '0;
    comp_cnt  = '0;
    picked    = 1'b0;
    min_key   = key_valid ? key : '1;
    if (state == RUN || state == DRAIN) begin
      comp      = busy & ~guard & lane_rdy;
      found_vec = comp & lane_found;
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      comp_cnt = comp_cnt + (KEY_W+1)'(comp[i]);
      if (found_vec[i] && (lane_key[i*KEY_W +: KEY_W] < min_key))
        min_key = lane_key[i*KEY_W +: KEY_W];
    end
    found_any = |found_vec;
    avail     = lane_rdy & ~busy & ~guard;
    // A found completion ends dispatching on the same cycle it is seen
    dispatch  = (state == RUN) && !found_any && (next_key <= KEY_LAST) && (|avail);
    if (dispatch) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (avail[i] && !picked) begin
          sel[i] = 1'b1;
          picked = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en) state_nxt = RUN;
      RUN: begin
`ifdef CRACK_FOUND_ABORT_EN
        if (found_any)
          state_nxt = DONE;
        else if (dispatch && (next_key == KEY_LAST))
          state_nxt = DRAIN;
`else
        if (found_any || (dispatch && (next_key == KEY_LAST)))
          state_nxt = DRAIN;
`endif
      end
      DRAIN: if ((busy & ~comp) == '0) state_nxt = DONE;
      DONE:  if (en) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy = (state == IDLE) || (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_en    <= '0;
      lane_key   <= '0;
      key_valid  <= 1'b0;
      key        <= '0;
      keys_tried <= '0;
      next_key   <= '0;
      busy       <= '0;
      guard      <= '0;
    end else if (accept) begin
      lane_en    <= '0;
      key_valid  <= 1'b0;
      key        <= '0;
      keys_tried <= '0;
      next_key   <= '0;
      busy       <= '0;
      guard      <= '0;
    end else begin
      lane_en    <= sel;
      guard      <= sel;
      busy       <= (busy & ~comp) | sel;
      keys_tried <= keys_tried + comp_cnt;
      if (found_any) begin
        key_valid <= 1'b1;
        key       <= min_key;
      end
      if (dispatch)
        next_key <= next_key + (KEY_W+1)'(1);
      for (int unsigned i = 0; i < LANES; i++) begin
        if (sel[i])
          lane_key[i*KEY_W +: KEY_W] <= next_key[KEY_W-1:0];
      end
`ifdef CRACK_FOUND_ABORT_EN
      if (state == RUN && found_any)
        busy <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_crack_dispatch.sv
// Self-checking bench for crack_dispatch: 2 lanes, 4-bit keys, behavioural lane model.
module tb_crack_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rdy;
  logic [1:0] lane_rdy;
  logic [1:0] lane_en;
  logic [7:0] lane_key;
  logic [1:0] lane_found;
  logic       key_valid;
  logic [3:0] key;
  logic [4:0] keys_tried;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [3:0] k;
    logic [4:0] t;
  } res_t;
  res_t sb[$];

  always #5 clk = ~clk;

  crack_dispatch #(.LANES(2), .KEY_W(4), .KEY_LAST(5'd15)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy),
    .lane_rdy(lane_rdy), .lane_en(lane_en), .lane_key(lane_key),
    .lane_found(lane_found), .key_valid(key_valid), .key(key),
    .keys_tried(keys_tried)
  );

  // Lane model: latches key on lane_en, raises rdy after a key-dependent latency
  int         mode = 0;
  logic [1:0] mrdy = 2'b11;
  logic [3:0] mkey [2] = '{4'd0, 4'd0};
  int         mcnt [2] = '{0, 0};
  logic       ta_en = 1'b0, tb_en = 1'b0;
  logic [3:0] tgt_a = 4'd0, tgt_b = 4'd0;

  function automatic int lat(input logic [3:0] k);
    case (mode)
      1:       return (k == 4'd3) ? 40 : 5;
      2:       return (k == 4'd0) ? 10 : ((k == 4'd1) ? 9 : 6);
      default: return 20;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (lane_en[i]) begin
        mrdy[i] <= 1'b0;
        mkey[i] <= lane_key[i*4 +: 4];
        mcnt[i] <= lat(lane_key[i*4 +: 4]) - 1;
      end else if (!mrdy[i]) begin
        if (mcnt[i] == 0) mrdy[i] <= 1'b1;
        else              mcnt[i] <= mcnt[i] - 1;
      end
    end
  end

  assign lane_rdy = mrdy;
  always_comb begin
    for (int i = 0; i < 2; i++)
      lane_found[i] = mrdy[i] && ((ta_en && mkey[i] == tgt_a) || (tb_en && mkey[i] == tgt_b));
  end

  // Dispatch monitor: keys must go out in order 0,1,2,... and never above 15
  int exp_key   = 0;
  int last_disp = -1;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (lane_en[i] === 1'b1) begin
        checks++;
        if (int'(lane_key[i*4 +: 4]) !== exp_key || exp_key > 15) begin
          errors++;
          $display("FAIL dispatch_key lane %0d got %0d exp %0d", i, lane_key[i*4 +: 4], exp_key);
        end
        last_disp = int'(lane_key[i*4 +: 4]);
        exp_key++;
      end
    end
  end

  task automatic wait_lanes_idle();
    int n = 0;
    while (mrdy != 2'b11 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (mrdy != 2'b11) begin
      checks++;
      errors++;
      $display("FAIL lanes_idle_timeout got %b exp 11", mrdy);
    end
  endtask

  task automatic start_search(input res_t e);
    wait_lanes_idle();
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_before_en got %b exp 1", rdy);
    end
    sb.push_back(e);
    exp_key = 0;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic finish_search(input string name);
    res_t e;
    int n = 0;
    while (rdy !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout rdy got %b exp 1", name, rdy);
    end
    wait_lanes_idle();
    repeat (3) @(negedge clk);
    e = sb.pop_front();
    checks += 3;
    if (key_valid !== e.v) begin
      errors++;
      $display("FAIL %s key_valid got %b exp %b", name, key_valid, e.v);
    end
    if (key !== e.k) begin
      errors++;
      $display("FAIL %s key got %0d exp %0d", name, key, e.k);
    end
    if (keys_tried !== e.t) begin
      errors++;
      $display("FAIL %s keys_tried got %0d exp %0d", name, keys_tried, e.t);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rdy, lane_en, lane_key, key_valid, key, keys_tried} !== {1'b1, 2'b00, 8'h00, 1'b0, 4'h0, 5'h00}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b en=%b key=%h kv=%b k=%0d kt=%0d exp rdy=1 rest 0",
               rdy, lane_en, lane_key, key_valid, key, keys_tried);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_found_9();
    mode = 0; ta_en = 1'b1; tgt_a = 4'd9; tb_en = 1'b0;
    start_search('{1'b1, 4'd9, 5'd10});
    finish_search("found_9");
  endtask

  task automatic test_not_found();
    mode = 0; ta_en = 1'b0; tb_en = 1'b0;
    start_search('{1'b0, 4'd0, 5'd16});
    finish_search("not_found");
    checks++;
    if (exp_key !== 16) begin
      errors++;
      $display("FAIL not_found dispatch_count got %0d exp 16", exp_key);
    end
  endtask

  task automatic test_lowest_found();
    mode = 1; ta_en = 1'b1; tgt_a = 4'd5; tb_en = 1'b1; tgt_b = 4'd3;
`ifdef CRACK_FOUND_ABORT_EN
    start_search('{1'b1, 4'd5, 5'd5});
`else
    start_search('{1'b1, 4'd3, 5'd6});
`endif
    finish_search("lowest_found");
  endtask

  task automatic test_simultaneous();
    int   n = 0;
    logic armed = 1'b0;
    mode = 2; ta_en = 1'b0; tb_en = 1'b0;
    start_search('{1'b0, 4'd0, 5'd16});
    while (!(armed && mrdy == 2'b11) && n < 200) begin
      @(negedge clk);
      if (mrdy == 2'b00) armed = 1'b1;
      n++;
    end
    checks += 2;
    if (keys_tried !== 5'd0 || lane_en !== 2'b00) begin
      errors++;
      $display("FAIL simul_comp_cycle got kt=%0d en=%b exp kt=0 en=00", keys_tried, lane_en);
    end
    @(negedge clk);
    if (keys_tried !== 5'd2 || lane_en !== 2'b00) begin
      errors++;
      $display("FAIL simul_after got kt=%0d en=%b exp kt=2 en=00", keys_tried, lane_en);
    end
    finish_search("simultaneous");
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    mode = 0; ta_en = 1'b1; tgt_a = 4'd9; tb_en = 1'b0;
    wait_lanes_idle();
    @(negedge clk);
    last_disp = -1;
    exp_key   = 0;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    while (last_disp != 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (last_disp != 7) begin
      errors++;
      $display("FAIL midrun_reach_7 got %0d exp 7", last_disp);
    end
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy, key_valid, keys_tried} !== {1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL midrun_after_rst got rdy=%b kv=%b kt=%0d exp 1 0 0", rdy, key_valid, keys_tried);
    end
    wait_lanes_idle();
    @(negedge clk);
    checks++;
    if ({key_valid, keys_tried} !== {1'b0, 5'd0}) begin
      errors++;
      $display("FAIL midrun_stale got kv=%b kt=%0d exp 0 0", key_valid, keys_tried);
    end
    start_search('{1'b1, 4'd9, 5'd10});
    finish_search("restart_found_9");
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    test_reset();
    test_found_9();
    test_not_found();
    test_lowest_found();
    test_simultaneous();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
